// File: rtl/uvmt_axis_st_fifo.sv
// uvmt_axis_st_fifo: synchronous AXI-Stream FIFO with registered handshake outputs.
// Beats taken on the slave port are replayed in order on the master port. Every
// sideband field travels with its beat. The block also reports the fill level and
// a count of delivered packets.
// The output beat, m_tvalid and s_tready all come straight from flops. Their next
// values are computed from the post-edge state, so no input feeds an output
// combinationally.

// Protocol invariants of the FIFO, kept apart from the datapath.
module uvmt_axis_st_fifo_chk #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 3,
    parameter int ENTRY_W = 57
) (
    input logic               clk,
    input logic               reset_n,
    input logic               s_tready,
    input logic               m_tvalid,
    input logic               m_tready,
    input logic [ENTRY_W-1:0] m_entry,
    input logic [CNT_W-1:0]   fill_level
);

    a_fill_bound : assert property (@(posedge clk) disable iff (!reset_n)
        fill_level <= CNT_W'(DEPTH));

    a_valid_tracks_fill : assert property (@(posedge clk) disable iff (!reset_n)
        m_tvalid == (fill_level != {CNT_W{1'b0}}));

    a_full_blocks_ready : assert property (@(posedge clk) disable iff (!reset_n)
        (fill_level == CNT_W'(DEPTH)) |-> !s_tready);

    a_empty_payload_zero : assert property (@(posedge clk) disable iff (!reset_n)
        !m_tvalid |-> (m_entry == {ENTRY_W{1'b0}}));

    a_stall_stable : assert property (@(posedge clk) disable iff (!reset_n)
        (m_tvalid && !m_tready) |=> (m_tvalid && $stable(m_entry)));

endmodule

module uvmt_axis_st_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
    input  logic                      s_tlast,
    input  logic [ID_WIDTH-1:0]       s_tid,
    input  logic [DEST_WIDTH-1:0]     s_tdest,
    input  logic [USER_WIDTH-1:0]     s_tuser,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_tkeep,
    output logic                      m_tlast,
    output logic [ID_WIDTH-1:0]       m_tid,
    output logic [DEST_WIDTH-1:0]     m_tdest,
    output logic [USER_WIDTH-1:0]     m_tuser,
    output logic [$clog2(DEPTH):0]    fill_level,
    output logic [31:0]               pkt_count
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int ENTRY_W    = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Storage and pointers. Pointers wrap naturally because DEPTH is a power of two.
    // fill_q disambiguates full from empty.
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fill_q, fill_d;

    // Registered interface state.
    logic               s_tready_q, s_tready_d;
    logic               m_tvalid_q, m_tvalid_d;
    logic [ENTRY_W-1:0] m_entry_q, m_entry_d;
    logic [31:0]        pkt_count_q, pkt_count_d;

    // Handshakes qualified by the registered valid/ready. This ensures that only
    // accepted beats are ever written, whatever the upstream does while stalled.
    logic               push_s;
    logic               pop_s;
    logic [ENTRY_W-1:0] s_entry_s;

    assign push_s    = s_tvalid & s_tready_q;
    assign pop_s     = m_tvalid_q & m_tready;
    assign s_entry_s = {s_tdata, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};

    assign s_tready   = s_tready_q;
    assign m_tvalid   = m_tvalid_q;
    assign fill_level = fill_q;
    assign pkt_count  = pkt_count_q;
    assign {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = m_entry_q;

    // Write side: store the accepted beat at wr_ptr and advance the pointer.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = s_entry_s;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Read side and occupancy: retire the head on a pop and track entries held.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   fill_d = fill_q + CNT_W'(1);
            2'b01:   fill_d = fill_q - CNT_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    // Next registered outputs are taken from the post-edge state. The head is read
    // from mem_d so that a beat written into an empty FIFO appears one edge later.
    // Ready depends only on the next occupancy, never on s_tvalid or m_tready.
    always_comb begin
        m_tvalid_d = 1'b0;
        m_entry_d  = {ENTRY_W{1'b0}};
        s_tready_d = (fill_d < DEPTH_CNT);
        if (fill_d != {CNT_W{1'b0}}) begin
            m_tvalid_d = 1'b1;
            m_entry_d  = mem_d[rd_ptr_d];
        end else begin
            m_tvalid_d = 1'b0;
            m_entry_d  = {ENTRY_W{1'b0}};
        end
    end

    // Delivered-packet counter: one count per popped beat carrying tlast, wrapping at 2^32.
    always_comb begin
        pkt_count_d = pkt_count_q;
        if (pop_s && m_tlast) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end else begin
            pkt_count_d = pkt_count_q;
        end
    end

    // State registers. Reset drops every stored beat and clears all outputs at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q       <= '{default: {ENTRY_W{1'b0}}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            fill_q      <= {CNT_W{1'b0}};
            s_tready_q  <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_entry_q   <= {ENTRY_W{1'b0}};
            pkt_count_q <= 32'd0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            s_tready_q  <= s_tready_d;
            m_tvalid_q  <= m_tvalid_d;
            m_entry_q   <= m_entry_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    uvmt_axis_st_fifo_chk #(
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W),
        .ENTRY_W (ENTRY_W)
    ) u_chk (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_tready   (s_tready_q),
        .m_tvalid   (m_tvalid_q),
        .m_tready   (m_tready),
        .m_entry    (m_entry_q),
        .fill_level (fill_q)
    );

endmodule

// File: tb/tb_uvmt_axis_st_fifo.sv
// Self-checking bench for uvmt_axis_st_fifo (DEPTH=4, 32-bit data).
// Accepted beats are queued and then compared in order when the FIFO delivers them.
module tb_uvmt_axis_st_fifo;

    localparam int DEPTH = 4;
    localparam int FW    = 3;
    localparam int N_RND = 10000;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic [3:0]  dest;
        logic [7:0]  user;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] s_tdata = 32'h0;
    logic [3:0]  s_tkeep = 4'h0;
    logic        s_tlast = 1'b0;
    logic [7:0]  s_tid = 8'h0;
    logic [3:0]  s_tdest = 4'h0;
    logic [7:0]  s_tuser = 8'h0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic [7:0]  m_tid;
    logic [3:0]  m_tdest;
    logic [7:0]  m_tuser;
    logic [FW-1:0] fill_level;
    logic [31:0] pkt_count;

    beat_t       sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_pop = 0;
    logic [31:0] exp_pkt = 32'h0;

    always #5 clk = ~clk;

    uvmt_axis_st_fifo #(
        .DATA_WIDTH (32),
        .ID_WIDTH   (8),
        .DEST_WIDTH (4),
        .USER_WIDTH (8),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tdata    (s_tdata),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .s_tid      (s_tid),
        .s_tdest    (s_tdest),
        .s_tuser    (s_tuser),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast),
        .m_tid      (m_tid),
        .m_tdest    (m_tdest),
        .m_tuser    (m_tuser),
        .fill_level (fill_level),
        .pkt_count  (pkt_count)
    );

    function automatic beat_t out_beat();
        out_beat = {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
    endfunction

    function automatic beat_t mk_fill(int i);
        beat_t b;
        b.data = 32'(i);
        b.keep = 4'hF;
        b.last = (i == 2 || i == 5);
        b.id   = 8'(16 + i);
        b.dest = 4'(i);
        b.user = 8'(160 + i);
        return b;
    endfunction

    // One clock of scoreboard traffic. It is entered at a negedge and returns at the next one.
    task automatic sb_cycle(input logic sv, input beat_t b, input logic mr, output logic acc);
        beat_t exp_b;
        s_tvalid = sv;
        s_tdata  = b.data;
        s_tkeep  = b.keep;
        s_tlast  = b.last;
        s_tid    = b.id;
        s_tdest  = b.dest;
        s_tuser  = b.user;
        m_tready = mr;
        #1;
        n_vec++;
        if (fill_level !== FW'(sb_q.size()) || m_tvalid !== (sb_q.size() != 0)
            || s_tready !== (sb_q.size() < DEPTH)) begin
            n_err++;
            $display("FAIL sb_status fill=%0d m_tvalid=%b s_tready=%b expected fill=%0d",
                     fill_level, m_tvalid, s_tready, sb_q.size());
        end
        acc = sv && (sb_q.size() < DEPTH);
        if (sb_q.size() != 0 && mr) begin
            exp_b = sb_q.pop_front();
            n_pop++;
            n_vec++;
            if (out_beat() !== exp_b) begin
                n_err++;
                $display("FAIL sb_beat got=%h expected=%h", out_beat(), exp_b);
            end
            if (exp_b.last) exp_pkt = exp_pkt + 32'd1;
        end else if (sb_q.size() == 0) begin
            n_vec++;
            if (out_beat() !== '0) begin
                n_err++;
                $display("FAIL sb_idle_zero got=%h expected=0", out_beat());
            end
        end
        if (acc) sb_q.push_back(b);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sb_drain(input string tag);
        logic acc;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) sb_cycle(1'b0, '0, 1'b1, acc);
        sb_cycle(1'b0, '0, 1'b1, acc);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain_timeout left=%0d expected=0", tag, sb_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || fill_level !== 3'd0 || pkt_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state s_tready=%b m_tvalid=%b fill=%0d pkt=%0d expected all 0",
                     s_tready, m_tvalid, fill_level, pkt_count);
        end
        n_vec++;
        if (out_beat() !== '0) begin
            n_err++;
            $display("FAIL reset_payload got=%h expected=0", out_beat());
        end
        reset_n = 1'b1;
        #1;
        n_vec++;
        if (s_tready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_ready got=%b expected=0", s_tready);
        end
        @(negedge clk);
        n_vec++;
        if (s_tready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_edge_ready got=%b expected=1", s_tready);
        end
    endtask

    task automatic test_single();
        beat_t b;
        b = '{data: 32'hDEAD_BEEF, keep: 4'hF, last: 1'b1, id: 8'h5A, dest: 4'h3, user: 8'h11};
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = b.data;
        s_tkeep  = b.keep;
        s_tlast  = b.last;
        s_tid    = b.id;
        s_tdest  = b.dest;
        s_tuser  = b.user;
        #1;
        n_vec++;
        if (m_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL single_no_bypass got=%b expected=0", m_tvalid);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        n_vec++;
        if (m_tvalid !== 1'b1 || fill_level !== 3'd1) begin
            n_err++;
            $display("FAIL single_valid m_tvalid=%b fill=%0d expected 1/1", m_tvalid, fill_level);
        end
        n_vec++;
        if (out_beat() !== b) begin
            n_err++;
            $display("FAIL single_fields got=%h expected=%h", out_beat(), b);
        end
        @(posedge clk);
        #1;
        exp_pkt = exp_pkt + 32'd1;
        n_vec++;
        if (m_tvalid !== 1'b0 || fill_level !== 3'd0 || pkt_count !== exp_pkt || out_beat() !== '0) begin
            n_err++;
            $display("FAIL single_after_pop m_tvalid=%b fill=%0d pkt=%0d payload=%h expected 0/0/%0d/0",
                     m_tvalid, fill_level, pkt_count, out_beat(), exp_pkt);
        end
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic acc;
        int   idx;
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            sb_cycle(1'b1, mk_fill(idx), 1'b0, acc);
            if (acc) idx++;
            if (c >= 3) begin
                n_vec++;
                if (s_tready !== 1'b0 || fill_level !== 3'd4 || m_tvalid !== 1'b1 || m_tdata !== 32'h0) begin
                    n_err++;
                    $display("FAIL fill_hold c=%0d s_tready=%b fill=%0d m_tvalid=%b m_tdata=%h expected 0/4/1/0",
                             c, s_tready, fill_level, m_tvalid, m_tdata);
                end
            end
        end
        n_vec++;
        if (idx != 4) begin
            n_err++;
            $display("FAIL fill_accepted got=%0d expected=4", idx);
        end
    endtask

    task automatic test_drain();
        logic acc;
        int   idx;
        int   pop0;
        idx  = 4;
        pop0 = n_pop;
        sb_cycle(1'b1, mk_fill(idx), 1'b1, acc);
        if (acc) idx++;
        n_vec++;
        if (s_tready !== 1'b1 || fill_level !== 3'd3) begin
            n_err++;
            $display("FAIL drain_ready_rise s_tready=%b fill=%0d expected 1/3", s_tready, fill_level);
        end
        for (int c = 0; c < 20 && idx < 6; c++) begin
            sb_cycle(1'b1, mk_fill(idx), 1'b1, acc);
            if (acc) idx++;
        end
        sb_drain("drain");
        n_vec++;
        if (n_pop - pop0 != 6 || idx != 6) begin
            n_err++;
            $display("FAIL drain_count popped=%0d sent=%0d expected 6/6", n_pop - pop0, idx);
        end
        n_vec++;
        if (pkt_count !== exp_pkt) begin
            n_err++;
            $display("FAIL drain_pkt got=%0d expected=%0d", pkt_count, exp_pkt);
        end
    endtask

    task automatic test_random();
        logic        acc;
        logic        offering;
        beat_t       cur;
        int          sent;
        int          cyc;
        int          pkt_len;
        int          pkt_pos;
        int          tl;
        logic [31:0] pkt_base;
        offering = 1'b0;
        cur      = '0;
        sent     = 0;
        cyc      = 0;
        pkt_len  = 1;
        pkt_pos  = 0;
        tl       = 0;
        pkt_base = exp_pkt;
        while ((sent < N_RND || sb_q.size() != 0) && cyc < 60000) begin
            if (!offering && sent < N_RND && $urandom_range(0, 1) == 1) begin
                if (pkt_pos == 0) pkt_len = int'($urandom_range(1, 16));
                cur.data = $urandom;
                cur.keep = 4'($urandom);
                cur.last = (pkt_pos == pkt_len - 1);
                cur.id   = 8'($urandom);
                cur.dest = 4'($urandom);
                cur.user = 8'($urandom);
                offering = 1'b1;
            end
            sb_cycle(offering, cur, 1'($urandom_range(0, 1)), acc);
            if (acc) begin
                offering = 1'b0;
                sent++;
                if (cur.last) begin
                    tl++;
                    pkt_pos = 0;
                end else begin
                    pkt_pos++;
                end
            end
            n_vec++;
            if (fill_level > 3'd4) begin
                n_err++;
                $display("FAIL rnd_fill_bound got=%0d expected<=4", fill_level);
            end
            cyc++;
        end
        s_tvalid = 1'b0;
        n_vec++;
        if (cyc >= 60000) begin
            n_err++;
            $display("FAIL rnd_timeout sent=%0d left=%0d expected all delivered", sent, sb_q.size());
        end
        n_vec++;
        if (pkt_count !== pkt_base + 32'(tl)) begin
            n_err++;
            $display("FAIL rnd_pkt_count got=%0d expected=%0d", pkt_count, pkt_base + 32'(tl));
        end
    endtask

    task automatic test_reset_mid();
        logic acc;
        beat_t b;
        for (int i = 0; i < 3; i++) begin
            b = '{data: 32'hA000_0000 + 32'(i), keep: 4'h7, last: 1'b0, id: 8'h21, dest: 4'h2, user: 8'(i)};
            sb_cycle(1'b1, b, 1'b0, acc);
        end
        s_tvalid = 1'b0;
        n_vec++;
        if (fill_level !== 3'd3) begin
            n_err++;
            $display("FAIL rstmid_prefill got=%0d expected=3", fill_level);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || fill_level !== 3'd0 || out_beat() !== '0) begin
            n_err++;
            $display("FAIL rstmid_async m_tvalid=%b s_tready=%b fill=%0d payload=%h expected all 0",
                     m_tvalid, s_tready, fill_level, out_beat());
        end
        sb_q.delete();
        exp_pkt = 32'h0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (s_tready !== 1'b1 || pkt_count !== 32'd0) begin
            n_err++;
            $display("FAIL rstmid_release s_tready=%b pkt=%0d expected 1/0", s_tready, pkt_count);
        end
        for (int i = 0; i < 3; i++) begin
            b = '{data: 32'hC0DE_0000 + 32'(i), keep: 4'hF, last: (i == 2), id: 8'h33, dest: 4'h9, user: 8'h70};
            sb_cycle(1'b1, b, 1'b1, acc);
        end
        sb_drain("rstmid");
        n_vec++;
        if (pkt_count !== 32'd1) begin
            n_err++;
            $display("FAIL rstmid_pkt got=%0d expected=1", pkt_count);
        end
    endtask

    task automatic test_wrap();
        logic  acc;
        beat_t b;
        force dut.pkt_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_count_q;
        #1;
        exp_pkt = 32'hFFFF_FFFF;
        n_vec++;
        if (pkt_count !== exp_pkt) begin
            n_err++;
            $display("FAIL wrap_preload got=%h expected=%h", pkt_count, exp_pkt);
        end
        @(negedge clk);
        b = '{data: 32'h1234_5678, keep: 4'hC, last: 1'b1, id: 8'h01, dest: 4'h1, user: 8'h02};
        sb_cycle(1'b1, b, 1'b1, acc);
        sb_drain("wrap");
        n_vec++;
        if (pkt_count !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_count got=%h expected=0", pkt_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uvmt_axis_st_fifo.md
Name: uvmt_axis_st_fifo

Overview:
- Synchronous AXI-Stream FIFO.
- Serves as the self-testing DUT between the master-side and slave-side AXI-Stream agent interfaces.
- Accepts beats on a slave port and replays them, order and sideband preserved, on a master port.
- Exposes fill level and a delivered-packet counter, used by the DUT checker and the scoreboard.

Parameters:
- DATA_WIDTH, 32, tdata width in bits; multiple of 8; tkeep width is DATA_WIDTH/8.
- ID_WIDTH, 8, tid width (min 1).
- DEST_WIDTH, 4, tdest width (min 1).
- USER_WIDTH, 8, tuser width (min 1).
- DEPTH, 4, storage entries; power of 2, >= 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s_tvalid  in  1  upstream beat valid.
- s_tready  out  1  FIFO can accept a beat.
- s_tdata  in  DATA_WIDTH  upstream data.
- s_tkeep  in  DATA_WIDTH/8  upstream byte qualifiers.
- s_tlast  in  1  upstream end of packet.
- s_tid  in  ID_WIDTH  upstream stream ID.
- s_tdest  in  DEST_WIDTH  upstream destination.
- s_tuser  in  USER_WIDTH  upstream user sideband.
- m_tvalid  out  1  downstream beat valid.
- m_tready  in  1  downstream ready.
- m_tdata / m_tkeep / m_tlast / m_tid / m_tdest / m_tuser  out  (widths as s_*)  downstream beat.
- fill_level  out  $clog2(DEPTH)+1  entries currently held.
- pkt_count  out  32  beats delivered with m_tlast=1.

Behaviour:
- Reset is asserted asynchronously and released synchronously to clk. While reset_n=0:
  - s_tready=0, m_tvalid=0, fill_level=0, pkt_count=0.
  - All m_t* payload outputs are 0.
  - Read and write pointers are 0.
- s_tready=1 from the first rising edge after reset_n deasserts, while fill_level<DEPTH.
- Push: s_tvalid && s_tready at an edge writes {tdata,tkeep,tlast,tid,tdest,tuser} to the entry at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: m_tvalid && m_tready at an edge retires the head entry; rd_ptr increments modulo DEPTH.
- m_tvalid = (fill_level != 0). m_t* always present the head entry.
- Latency: a beat pushed at edge N is visible on m_* after edge N (m_tvalid=1 in cycle N+1). There is no same-cycle bypass when empty.
- fill_level next = fill_level + push - pop. Simultaneous push and pop leaves it unchanged.
- Full: fill_level==DEPTH gives s_tready=0, so no push. A pop at that edge raises s_tready in the next cycle, not the same one. This gives a registered ready, with no combinational m_tready->s_tready path.
- Empty: m_tvalid=0 and m_* hold 0. A push when empty is the only event possible.
- AXI-Stream stability: while m_tvalid && !m_tready, every m_t* is held stable. m_tvalid never drops without a handshake.
- The FIFO has no dependency on s_tvalid when computing s_tready.
- Upstream violations (s_* changing while s_tvalid && !s_tready) do not corrupt stored entries; only handshaken beats are written.
- pkt_count increments on each pop with m_tlast=1 and wraps from 32'hFFFF_FFFF to 0.
- Pointers wrap silently. A full/empty distinction is made via an extra MSB or via fill_level.
- Reset mid-packet discards all stored beats immediately, and the partial packet is lost. After release the FIFO behaves as freshly reset.
- tkeep, tid, tdest and tuser pass through untouched. No packing and no null-byte removal.

Test Plan:
- Reset release, m_tready=1, push one beat tdata=32'hDEAD_BEEF, tkeep=4'hF, tlast=1, tid=8'h5A:
  - m_tvalid=1 exactly one cycle later with identical fields.
  - pkt_count=1 after the pop; fill_level returns to 0.
- Fill with m_tready=0, DEPTH=4, beats 0..5 offered back-to-back:
  - Beats 0..3 accepted; s_tready=0 after the 4th.
  - fill_level=4; m_tdata=0 held stable for 10 cycles.
- From full, assert m_tready=1 with s_tvalid=1 continuously:
  - s_tready rises the cycle after the first pop.
  - Output order is 0,1,2,3,4,5; no beat lost or duplicated.
- Random s_tvalid/m_tready, 50% each, 10000 beats, packets of 1..16 beats:
  - Scoreboard matches every field in order.
  - pkt_count equals the number of tlast beats sent.
  - fill_level never exceeds 4.
- Assert reset_n=0 for 1 cycle with fill_level=3, mid-packet:
  - m_tvalid, s_tready and fill_level go 0 asynchronously.
  - The next packet after release passes cleanly.
- Preload pkt_count to 32'hFFFF_FFFF (force) and deliver one tlast beat -> pkt_count=0.
